leaf_user_arbiter: RTL and testbench
====================================

Name: leaf_user_arbiter

Overview:
- Parametrised N-to-1 merge stage between multiple HLS operator output streams and a single leaf-interface input stream.
- Each user port has a 2-entry skid FIFO.
- A round-robin arbiter fills a registered output stage that tags each beat with its source port index.
- Successor to the single-port direct user-to-interface hookup: generalised in port count and payload width, and adds fairness, buffering and port tagging.

Parameters:
- NUM_PORTS, 4, number of user output streams merged (1..16).
- PAYLOAD_BITS, 32, data width of each beat.
- NUM_PORT_BITS, 4, width of the source-port tag; must be >= clog2(NUM_PORTS), checked at elaboration.
- BURST_LEN, 4, maximum consecutive grants to one port; used only when LEAF_ARB_LOCK_EN is defined.

Ports:
- clk_user  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset: 0 = reset, sampled on clk_user.
- din_user  in  NUM_PORTS*PAYLOAD_BITS  per-port payload; port i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- vld_user  in  NUM_PORTS  per-port valid (ap_vld).
- ack_arb2user  out  NUM_PORTS  per-port acknowledge (ap_ack).
- dout_arb  out  PAYLOAD_BITS  merged payload to interface.
- dout_port  out  NUM_PORT_BITS  source port index of dout_arb.
- vld_arb  out  1  merged valid.
- ack_interface2arb  in  1  interface acknowledge.

Behaviour:
- Handshake on every stream: a transfer occurs in a cycle where vld and ack are both 1. The producer holds vld and data stable until the transfer.
- Reset (reset==0 at an edge):
  - FIFO counts = 0, vld_arb = 0, dout_arb = 0, dout_port = 0.
  - Round-robin pointer = NUM_PORTS-1, so port 0 wins first.
  - ack_arb2user = 0 while reset is low.
  - Reset mid-operation discards all buffered beats; no partial beat survives.
- Ingress acknowledge: ack_arb2user[i] = (count_i != 2), decoded from registered state only.
  - No combinational path from ack_interface2arb or vld_user to any ack.
  - A pop from a full FIFO does not raise ack in the same cycle.
- FIFO i:
  - Push on vld_user[i] & ack_arb2user[i].
  - Pop when the arbiter grants port i.
  - Simultaneous push and pop leaves count unchanged, with data ordering preserved.
- Output stage:
  - Load condition: a register holding {dout_arb, dout_port} with vld_arb may load when vld_arb==0 or (vld_arb & ack_interface2arb).
  - If the stage can load and any FIFO is non-empty, grant the first non-empty port scanning upward (modulo NUM_PORTS) from pointer+1.
  - On a grant: load that head, set vld_arb = 1, pop the FIFO, set pointer = granted index.
  - If the stage can load and all FIFOs are empty: vld_arb <= 0; data and tag hold their last values.
  - While vld_arb==1 and ack_interface2arb==0, dout_arb, dout_port and vld_arb are held stable.
- Latency: a beat accepted from user port i in cycle t appears on vld_arb in cycle t+2 at the earliest.
- Throughput: one beat per cycle aggregate. Each port sustains 1 beat/cycle when it is the only active port.
- Fairness: with all ports continuously active, grants follow 0,1,..,N-1,0,... with no starvation.
- NUM_PORTS==1: the pointer is degenerate, dout_port is constantly 0, and behaviour is a 2-deep pipe.

Optional Feature:
- Macro: LEAF_ARB_LOCK_EN.
- Defined:
  - After granting port p, the arbiter keeps granting p while FIFO p is non-empty at load time, up to BURST_LEN consecutive grants.
  - It then resumes the round-robin scan from p+1.
  - A 0..BURST_LEN-1 burst counter resets to 0 on every change of grant, and on reset.
  - Intended for keeping multi-beat packets from one port contiguous.
- Undefined: pure per-beat round-robin as above. The burst counter is not instantiated and BURST_LEN is ignored.

Decomposition:
- Package leaf_arb_pkg holds:
  - the skid depth constant (2);
  - a function computing clog2 for the NUM_PORT_BITS check;
  - the default PAYLOAD_BITS/NUM_PORT_BITS values shared with the leaf wrappers.
- Sub-module leaf_skid_fifo:
  - 2-entry FIFO with vld/ack on both sides; ack = not full; parametrised on PAYLOAD_BITS.
  - Instantiated NUM_PORTS times via generate.
- Arbiter and output stage stay in the top module.

Test Plan:
- Reset: hold reset=0 for 3 cycles with vld_user=4'b1111 -> ack_arb2user=0 and vld_arb=0 throughout. The first cycle after release gives ack_arb2user=4'b1111.
- Single port: port 2 sends 0x11,0x22,0x33 back-to-back with ack_interface2arb=1 -> dout_arb sequence 0x11,0x22,0x33 on consecutive cycles starting at t+2, dout_port=2 each beat.
- Fairness: all 4 ports continuously valid, payload = port index, ack_interface2arb=1 -> dout_port = 0,1,2,3,0,1,... for 16 beats with no gaps.
- Backpressure: ack_interface2arb=0 for 10 cycles with all ports sending -> every FIFO fills to 2, all acks drop, and dout_arb/dout_port stay stable. On release, 9 beats drain with no loss, duplication or reordering within a port.
- Reset mid-traffic: assert reset with 5 beats buffered -> next cycle vld_arb=0. After release, no stale beat is emitted.
- LEAF_ARB_LOCK_EN with BURST_LEN=4, ports 0 and 1 continuously valid -> dout_port = 0,0,0,0,1,1,1,1,0... Without the macro -> 0,1,0,1.

Source files
------------

// File: rtl/leaf_arb_pkg.sv
// leaf_arb_pkg: constants and helpers shared by the leaf user arbiter and the leaf wrappers.
package leaf_arb_pkg;
  localparam int SKID_DEPTH        = 2;
  localparam int DEF_PAYLOAD_BITS  = 32;
  localparam int DEF_NUM_PORT_BITS = 4;
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/leaf_user_arbiter_if.sv
// leaf_user_arbiter_if: user-stream ingress and merged-stream egress bundle of the leaf user arbiter.
//   din_user/vld_user/ack_arb2user : NUM_PORTS user streams (port i at din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS])
//   dout_arb/dout_port/vld_arb/ack_interface2arb : merged stream tagged with its source port
//   master : producers and interface sink; slave : the arbiter
interface leaf_user_arbiter_if
  import leaf_arb_pkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int PAYLOAD_BITS  = DEF_PAYLOAD_BITS,
  parameter int NUM_PORT_BITS = DEF_NUM_PORT_BITS
);
  logic [NUM_PORTS*PAYLOAD_BITS-1:0] din_user;
  logic [NUM_PORTS-1:0]              vld_user;
  logic [NUM_PORTS-1:0]              ack_arb2user;
  logic [PAYLOAD_BITS-1:0]           dout_arb;
  logic [NUM_PORT_BITS-1:0]          dout_port;
  logic                              vld_arb;
  logic                              ack_interface2arb;
  modport master (
    output din_user, vld_user, ack_interface2arb,
    input  ack_arb2user, dout_arb, dout_port, vld_arb
  );
  modport slave (
    input  din_user, vld_user, ack_interface2arb,
    output ack_arb2user, dout_arb, dout_port, vld_arb
  );
endinterface

// File: rtl/leaf_skid_fifo.sv
// leaf_skid_fifo: 2-entry skid FIFO with vld/ack on both sides.
//   clk_i, rst_ni (sync, active-low); in_data_i/in_vld_i/in_ack_o ingress; out_data_o/out_vld_o/out_ack_i egress
module leaf_skid_fifo
  import leaf_arb_pkg::*;
#(
  parameter int PAYLOAD_BITS = DEF_PAYLOAD_BITS
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [PAYLOAD_BITS-1:0] in_data_i,
  input  logic                    in_vld_i,
  output logic                    in_ack_o,
  output logic [PAYLOAD_BITS-1:0] out_data_o,
  output logic                    out_vld_o,
  input  logic                    out_ack_i
);
  logic [PAYLOAD_BITS-1:0] mem_q [SKID_DEPTH];
  logic                    wr_q, rd_q, push, pop;
  logic [1:0]              cnt_q, cnt_d;
  // ack comes from the registered count only, so a pop from a full FIFO re-opens ingress one cycle later
  assign in_ack_o   = rst_ni && cnt_q != 2'(SKID_DEPTH);
  assign out_vld_o  = cnt_q != 2'd0;
  assign out_data_o = mem_q[rd_q];
  assign push       = in_vld_i && in_ack_o;
  assign pop        = out_vld_o && out_ack_i;
  assign cnt_d      = cnt_q + 2'(push) - 2'(pop);
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
    end else begin
      if (push) mem_q[wr_q] <= in_data_i;
      wr_q  <= wr_q ^ push;
      rd_q  <= rd_q ^ pop;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/leaf_user_arbiter.sv
// leaf_user_arbiter: round-robin N-to-1 merge of HLS user streams into one tagged leaf-interface stream.
//   clk_user : clock, all logic on rising edge
//   reset    : synchronous active-low reset
//   bus      : leaf_user_arbiter_if.slave (user streams in, merged stream + source port tag out)
//   Optional LEAF_ARB_LOCK_EN: keep granting the last port while it has data, up to BURST_LEN beats.
module leaf_user_arbiter
  import leaf_arb_pkg::*;
#(
  parameter int NUM_PORTS     = 4,
  parameter int PAYLOAD_BITS  = DEF_PAYLOAD_BITS,
  parameter int NUM_PORT_BITS = DEF_NUM_PORT_BITS,
  parameter int BURST_LEN     = 4
) (
  input logic                clk_user,
  input logic                reset,
  leaf_user_arbiter_if.slave bus
);
  localparam int IW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  if (NUM_PORTS < 1 || NUM_PORTS > 16) begin : g_bad_ports
    $error("NUM_PORTS must be 1..16");
  end
  if (NUM_PORT_BITS < 1 || NUM_PORT_BITS < clog2_f(NUM_PORTS)) begin : g_bad_tag
    $error("NUM_PORT_BITS too narrow for NUM_PORTS");
  end
  if (BURST_LEN < 1) begin : g_bad_burst
    $error("BURST_LEN must be >= 1");
  end
  logic [NUM_PORTS-1:0]     f_vld, ack, pop;
  logic [PAYLOAD_BITS-1:0]  f_data [NUM_PORTS];
  logic                     vld_q, vld_d, can_load, load, gnt_vld;
  logic [PAYLOAD_BITS-1:0]  data_q, data_d, gnt_data;
  logic [NUM_PORT_BITS-1:0] port_q, port_d;
  logic [IW-1:0]            ptr_q, ptr_d, gnt_idx, scan;
  logic [IW:0]              sum;
  genvar i;
  for (i = 0; i < NUM_PORTS; i++) begin : g_fifo
    leaf_skid_fifo #(.PAYLOAD_BITS(PAYLOAD_BITS)) u_fifo (
      .clk_i     (clk_user),
      .rst_ni    (reset),
      .in_data_i (bus.din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
      .in_vld_i  (bus.vld_user[i]),
      .in_ack_o  (ack[i]),
      .out_data_o(f_data[i]),
      .out_vld_o (f_vld[i]),
      .out_ack_i (pop[i])
    );
  end
`ifdef LEAF_ARB_LOCK_EN
  localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  logic [BW-1:0] burst_q, burst_d;
  logic          lock_q, lock_d, ext;
`endif
  always_comb begin
    can_load = !vld_q || bus.ack_interface2arb;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    gnt_data = '0;
    sum      = '0;
    scan     = '0;
    // scan downward so the nearest non-empty port after the pointer is the last one written
    for (int k = NUM_PORTS; k >= 1; k--) begin
      sum  = {1'b0, ptr_q} + (IW+1)'(k);
      scan = sum >= (IW+1)'(NUM_PORTS) ? IW'(sum - (IW+1)'(NUM_PORTS)) : IW'(sum);
      if (f_vld[scan]) begin
        gnt_vld  = 1'b1;
        gnt_idx  = scan;
        gnt_data = f_data[scan];
      end
    end
`ifdef LEAF_ARB_LOCK_EN
    // ptr_q is the last granted port once lock_q is set; extend its burst while it still has data
    ext = lock_q && f_vld[ptr_q] && burst_q != BW'(BURST_LEN - 1);
    if (ext) begin
      gnt_vld  = 1'b1;
      gnt_idx  = ptr_q;
      gnt_data = f_data[ptr_q];
    end
`endif
    load   = can_load && gnt_vld;
    pop    = load ? (NUM_PORTS'(1) << gnt_idx) : '0;
    vld_d  = can_load ? gnt_vld : vld_q;
    data_d = load ? gnt_data : data_q;
    port_d = load ? NUM_PORT_BITS'(gnt_idx) : port_q;
    ptr_d  = load ? gnt_idx : ptr_q;
`ifdef LEAF_ARB_LOCK_EN
    burst_d = load ? (ext ? burst_q + BW'(1) : '0) : burst_q;
    lock_d  = lock_q || load;
`endif
  end
  always_ff @(posedge clk_user) begin
    if (!reset) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      port_q <= '0;
      ptr_q  <= IW'(NUM_PORTS - 1);
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      port_q <= port_d;
      ptr_q  <= ptr_d;
    end
  end
`ifdef LEAF_ARB_LOCK_EN
  always_ff @(posedge clk_user) begin
    if (!reset) begin
      burst_q <= '0;
      lock_q  <= 1'b0;
    end else begin
      burst_q <= burst_d;
      lock_q  <= lock_d;
    end
  end
`endif
  assign bus.ack_arb2user = ack;
  assign bus.dout_arb     = data_q;
  assign bus.dout_port    = port_q;
  assign bus.vld_arb      = vld_q;
endmodule

// File: tb/tb_leaf_user_arbiter.sv
// tb_leaf_user_arbiter: directed scoreboard bench for leaf_user_arbiter.
module tb_leaf_user_arbiter;
  localparam int N   = 4;
  localparam int PB  = 32;
  localparam int NPB = 4;
`ifdef LEAF_ARB_LOCK_EN
  localparam int LOCK = 1;
`else
  localparam int LOCK = 0;
`endif
  logic clk_user = 1'b0;
  logic reset;
  always #5 clk_user = ~clk_user;
  leaf_user_arbiter_if #(.NUM_PORTS(N), .PAYLOAD_BITS(PB), .NUM_PORT_BITS(NPB)) bus ();
  leaf_user_arbiter #(.NUM_PORTS(N), .PAYLOAD_BITS(PB), .NUM_PORT_BITS(NPB), .BURST_LEN(4)) dut (
    .clk_user(clk_user),
    .reset   (reset),
    .bus     (bus)
  );
  int tests = 0, fails = 0;
  int cyc = 0;
  int n_acc = 0, n_hs = 0;
  logic [PB-1:0] src_q [N][$];
  logic [PB-1:0] exp_q [N][$];
  int exp_order[$];
  int hs_cyc[$];
  int acc_cyc[$];
  logic rst_v = 1'b0, sink_v = 1'b1;
  logic [N-1:0] pend = '0;
  logic rst_prev = 1'b1, stall = 1'b0;
  logic [PB-1:0] hold_d;
  logic [NPB-1:0] hold_p;
  int mon_p;
  always @(posedge clk_user) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask
  // one clock: account for the transfer at this edge, drive the next cycle, note what will transfer next
  task automatic cycle();
    @(posedge clk_user);
    #1;
    for (int p = 0; p < N; p++) if (pend[p]) begin
      if (rst_v) exp_q[p].push_back(src_q[p][0]);
      n_acc++;
      void'(src_q[p].pop_front());
    end
    reset = rst_v;
    bus.ack_interface2arb = sink_v;
    for (int p = 0; p < N; p++) begin
      bus.vld_user[p] = src_q[p].size() > 0;
      bus.din_user[p*PB +: PB] = src_q[p].size() > 0 ? src_q[p][0] : '0;
    end
    @(negedge clk_user);
    pend = bus.vld_user & bus.ack_arb2user;
    for (int p = 0; p < N; p++) if (pend[p]) acc_cyc.push_back(cyc);
  endtask
  task automatic run(input int n);
    repeat (n) cycle();
  endtask
  function automatic bit busy();
    for (int p = 0; p < N; p++) if (src_q[p].size() > 0 || exp_q[p].size() > 0) return 1'b1;
    return 1'b0;
  endfunction
  task automatic drain(input string name, input int budget);
    int b;
    b = 0;
    while (b < budget && busy()) begin
      cycle();
      b++;
    end
    run(2);
    check(name, 64'(b < budget), 64'd1);
  endtask
  task automatic flush();
    for (int p = 0; p < N; p++) begin
      src_q[p].delete();
      exp_q[p].delete();
    end
    exp_order.delete();
  endtask
  task automatic do_reset();
    rst_v = 1'b0;
    flush();
    run(2);
    rst_v = 1'b1;
    run(1);
    hs_cyc.delete();
    acc_cyc.delete();
    n_acc = 0;
    n_hs = 0;
  endtask
  // monitor: reset behaviour, stall stability, and scoreboard pops on every output handshake
  initial begin
    forever begin
      @(negedge clk_user);
      if (!reset) begin
        check("reset_ack", 64'(bus.ack_arb2user), 64'd0);
        if (!rst_prev) check("reset_vld_arb", 64'(bus.vld_arb), 64'd0);
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("stall_vld", 64'(bus.vld_arb), 64'd1);
          check("stall_data", 64'(bus.dout_arb), 64'(hold_d));
          check("stall_port", 64'(bus.dout_port), 64'(hold_p));
        end
        if (bus.vld_arb && bus.ack_interface2arb) begin
          mon_p = int'(bus.dout_port);
          hs_cyc.push_back(cyc);
          n_hs++;
          tests++;
          if (mon_p >= N || exp_q[mon_p].size() == 0) begin
            fails++;
            $display("FAIL stale_beat: got port %0d data %0h, required no beat", mon_p, bus.dout_arb);
          end else if (bus.dout_arb !== exp_q[mon_p][0]) begin
            fails++;
            $display("FAIL beat_data port %0d: got %0h, required %0h", mon_p, bus.dout_arb, exp_q[mon_p][0]);
          end
          if (mon_p < N && exp_q[mon_p].size() > 0) void'(exp_q[mon_p].pop_front());
          if (exp_order.size() > 0) check("grant_order", 64'(mon_p), 64'(exp_order.pop_front()));
        end
        stall  = bus.vld_arb && !bus.ack_interface2arb;
        hold_d = bus.dout_arb;
        hold_p = bus.dout_port;
      end
      rst_prev = reset;
    end
  end
  initial begin
    int gaps;
    reset = 1'b0;
    bus.vld_user = '0;
    bus.din_user = '0;
    bus.ack_interface2arb = 1'b1;
    // reset held 3 cycles with every port valid
    for (int p = 0; p < N; p++) src_q[p].push_back(PB'(32'hA0 + p));
    run(3);
    check("reset_dout_arb", 64'(bus.dout_arb), 64'd0);
    check("reset_dout_port", 64'(bus.dout_port), 64'd0);
    rst_v = 1'b1;
    cycle();
    check("ack_after_reset", 64'(bus.ack_arb2user), 64'hF);
    for (int k = 0; k < N; k++) exp_order.push_back(k);
    drain("reset_drain", 100);
    // single port, back-to-back
    do_reset();
    src_q[2].push_back(32'h11);
    src_q[2].push_back(32'h22);
    src_q[2].push_back(32'h33);
    repeat (3) exp_order.push_back(2);
    drain("single_drain", 100);
    check("single_beats", 64'(hs_cyc.size()), 64'd3);
    check("single_accepts", 64'(acc_cyc.size()), 64'd3);
    if (hs_cyc.size() == 3 && acc_cyc.size() == 3) begin
      check("single_latency", 64'(hs_cyc[0]), 64'(acc_cyc[0] + 2));
      check("single_accept_b2b", 64'(acc_cyc[2]), 64'(acc_cyc[0] + 2));
      check("single_b2b_1", 64'(hs_cyc[1]), 64'(hs_cyc[0] + 1));
      check("single_b2b_2", 64'(hs_cyc[2]), 64'(hs_cyc[0] + 2));
    end
    // fairness, all ports continuously valid
    do_reset();
    for (int p = 0; p < N; p++) repeat (4) src_q[p].push_back(PB'(p));
    for (int k = 0; k < 16; k++) exp_order.push_back(LOCK ? (k / 4) % 4 : k % 4);
    drain("fair_drain", 200);
    check("fair_beats", 64'(hs_cyc.size()), 64'd16);
    gaps = 0;
    for (int k = 1; k < hs_cyc.size(); k++) if (hs_cyc[k] != hs_cyc[k-1] + 1) gaps++;
    check("fair_gaps", 64'(gaps), 64'd0);
    // backpressure
    do_reset();
    sink_v = 1'b0;
    for (int p = 0; p < N; p++) for (int b = 0; b < 3; b++) src_q[p].push_back(PB'((p << 8) | b));
    run(10);
    check("bp_acks_low", 64'(bus.ack_arb2user), 64'd0);
    check("bp_accepted", 64'(n_acc), 64'd9);
    check("bp_held_vld", 64'(bus.vld_arb), 64'd1);
    check("bp_held_port", 64'(bus.dout_port), 64'd0);
    check("bp_held_data", 64'(bus.dout_arb), 64'h000);
    sink_v = 1'b1;
    drain("bp_drain", 200);
    check("bp_total", 64'(n_hs), 64'd12);
    // reset mid-traffic with 5 beats buffered
    do_reset();
    sink_v = 1'b0;
    for (int b = 0; b < 3; b++) src_q[0].push_back(PB'(32'h100 + b));
    for (int b = 0; b < 2; b++) src_q[1].push_back(PB'(32'h200 + b));
    run(5);
    check("mid_buffered", 64'(n_acc), 64'd5);
    rst_v = 1'b0;
    flush();
    n_hs = 0;
    run(2);
    check("mid_reset_vld", 64'(bus.vld_arb), 64'd0);
    rst_v = 1'b1;
    sink_v = 1'b1;
    run(6);
    check("mid_no_stale", 64'(n_hs), 64'd0);
    // two ports continuously valid: alternation, or bursts of 4 with locking
    do_reset();
    for (int b = 0; b < 8; b++) begin
      src_q[0].push_back(PB'(32'h300 + b));
      src_q[1].push_back(PB'(32'h400 + b));
    end
    for (int k = 0; k < 16; k++) exp_order.push_back(LOCK ? (k / 4) % 2 : k % 2);
    drain("pair_drain", 200);
    check("pair_beats", 64'(n_hs), 64'd16);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
